// File: rtl/conv_result_writer.sv
// conv_result_writer: sink for the convolutor's raster-ordered output stream.
// Drops the K_SIZE-1 wrap-around columns at the end of each row and writes the
// (N-K_SIZE+1)^2 legal results densely into a result RAM, then pulses done_o.
module conv_result_writer #(
    parameter int N          = 16,
    parameter int DATA_WIDTH = 16,
    parameter int K_SIZE     = 3,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int M      = N - K_SIZE + 1;
    localparam int COL_W  = (N > 1) ? $clog2(N) : 1;
    localparam int ROW_W  = (M > 1) ? $clog2(M) : 1;
    localparam int WPTR_W = (M * M > 1) ? $clog2(M * M) : 1;

    // Last column index of a row, last column that carries a legal result, last row.
    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(N - 1);
    localparam logic [COL_W-1:0] COL_KEEP_MAX = COL_W'(N - K_SIZE);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(M - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [WPTR_W-1:0]     wptr_q, wptr_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    // Next-state, counter and registered-output logic; start_i always wins and
    // re-arms the frame with cleared counters and a cleared error flag.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        wptr_d    = wptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = err_q;
        busy_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                    wptr_d  = '0;
                    err_d   = 1'b0;
                end else if (valid_i) begin
                    err_d = 1'b1;
                end
            end

            RUN: begin
                if (start_i) begin
                    col_d  = '0;
                    row_d  = '0;
                    wptr_d = '0;
                    err_d  = 1'b0;
                end else if (valid_i) begin
                    if (col_q <= COL_KEEP_MAX) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ADDR_WIDTH'(wptr_q);
                        wr_data_d = data_i;
                        wptr_d    = wptr_q + 1'b1;
                    end
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if ((row_q == ROW_LAST) && (col_q == COL_KEEP_MAX)) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                done_d = 1'b1;
                if (start_i) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                    wptr_d  = '0;
                    err_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                    if (valid_i) begin
                        err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // busy stays up through the final write cycle and drops as done rises.
        busy_d = (state_d != IDLE);
    end

    // State, counter and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            wptr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            wptr_q    <= wptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: doc/conv_result_writer.md
# conv_result_writer

Sink-side companion to the image-ROM reader and convolutor path. It consumes the convolutor's raster-ordered output stream (data plus valid) and discards the K_SIZE−1 wrap-around positions at the end of each image row. It writes only the (N−K_SIZE+1)² legal results, at dense addresses, through a simple-dual-port result RAM write port. It signals completion once a full result frame has been stored.

## Interface
- N, 16, input image width/height in pixels
- DATA_WIDTH, 16, sample width
- K_SIZE, 3, kernel edge length
- ADDR_WIDTH, 8, result RAM address width; must satisfy 2^ADDR_WIDTH ≥ (N−K_SIZE+1)²
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start_i  input  1  one-cycle pulse: arm for a new frame, clears counters
- data_i  input  DATA_WIDTH  convolution result
- valid_i  input  1  data_i qualifies this cycle
- wr_en_o  output  1  result RAM write enable
- wr_addr_o  output  ADDR_WIDTH  result RAM write address
- wr_data_o  output  DATA_WIDTH  result RAM write data
- busy_o  output  1  high while in RUN
- done_o  output  1  one-cycle pulse after last result written
- err_o  output  1  sticky: valid_i seen while not in RUN; cleared by start_i or reset

## Operation
- M = N−K_SIZE+1. Internal counters: col (0..N−1), row (0..M−1), wptr (0..M²−1).
- States: IDLE, RUN, DONE.
- IDLE: outputs idle. start_i → RUN, with col=row=wptr=0 and err_o cleared. valid_i in IDLE sets err_o; data is dropped.
- RUN, each cycle with valid_i=1:
  - col ≤ N−K_SIZE: write data_i at wptr, then wptr++.
  - col > N−K_SIZE: sample discarded, no write.
  - col advances; at col=N−1 it wraps to 0 and row++.
- RUN, valid_i=0: all counters hold; gaps of any length are legal.
- Last write (row=M−1, col=M−1) → DONE. The remaining K_SIZE−1 columns of the last row are never expected.
- DONE: lasts exactly one cycle, asserts done_o, then → IDLE. valid_i in DONE sets err_o.
- start_i in RUN: restart. Counters clear and the current-cycle valid_i is ignored. No write that cycle; any write registered from the previous cycle still completes.
- start_i in DONE: takes priority and goes to RUN; done_o still pulses that cycle.
- wptr is never compared beyond M²−1. Counter widths are sized from N and M with $clog2; no wrap ambiguity.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; col, row and wptr = 0; wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, done_o=0, err_o=0.
- Write latency is 1 cycle. data_i/valid_i sampled at edge t appear on wr_en_o/wr_addr_o/wr_data_o after edge t, stable for the whole cycle t+1. All outputs are registered.
- wr_data_o and wr_addr_o hold their last values when wr_en_o=0.
- busy_o rises the cycle after start_i is sampled and falls the cycle done_o rises.
- done_o occupies the cycle immediately after the final write cycle, i.e. 2 cycles after the final valid_i sample.
- With continuous valid_i, a frame takes M·N−(K_SIZE−1) valid cycles. The defaults give 222 valid cycles and 196 writes.

## Test plan
- Default parameters, start_i, then 222 consecutive valid_i cycles with data_i = position index 0..221:
  - 196 writes, to addresses 0..195.
  - Address 14 holds data 16, address 195 holds data 221.
  - Positions 14 and 15 are never written.
  - done_o pulses once, 2 cycles after the last valid.
- Same stream with valid_i toggling 1/0 every cycle: identical write contents and order, and no writes on gap cycles.
- After done, hold valid_i=1 for 3 cycles: no writes; err_o=1 and stays set until the next start_i.
- Mid-frame restart:
  - After 50 valid cycles, pulse start_i, then send a full 222-cycle frame with data_i = 1000 + index.
  - Address 0 is written with 1000 and done_o pulses exactly once.
- Assert rst=0 asynchronously mid-RUN, with no clock edge: all outputs go to 0 immediately; after release, a new start_i and frame complete normally.
- N=8, K_SIZE=3, ADDR_WIDTH=6, continuous frame:
  - 36 writes, with 2 discards per row.
  - 46 valid cycles total.
  - done_o after address 35.
